// File: rtl/rnn_seq_ctrl.sv
// rtl/rnn_seq_ctrl.sv - Bus-master sequencer driving the RNN accelerator core
//
// Optional feature macro: POLL_TIMEOUT_EN
//   defined   : POLL gives up after POLL_MAX attempts and returns res_err=1, res_data=0
//   undefined : POLL waits indefinitely, res_err is tied low
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid/in_ready/in_data/in_last   embedding element stream
//   m_write/m_read/m_addr/m_wdata/m_rdata   core register port (m_rdata combinational)
//   res_valid/res_ready/res_data/res_err    dense-layer result handshake
//   busy              low only when idle between sequences
//   step_cnt          characters stepped in the current sequence
module rnn_seq_ctrl #(
    parameter int EMB_LEN   = 4,
    parameter int STEP_WAIT = 1100,
    parameter int POLL_MAX  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        m_write,
    output logic        m_read,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_err,
    output logic        busy,
    output logic [15:0] step_cnt
);

    localparam logic [7:0]  ELEM_LAST = 8'(EMB_LEN - 1);
    localparam logic [31:0] WAIT_LAST = 32'(STEP_WAIT - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_MAX - 1);

    typedef enum logic [2:0] {
        ACCEPT, WR_IN, START, WAIT, DENSE, POLL, READ, OUT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  elem_cnt_q, elem_cnt_d;
    logic [15:0] elem_reg_q, elem_reg_d;
    logic        last_flag_q, last_flag_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic [15:0] res_data_q, res_data_d;
`ifdef POLL_TIMEOUT_EN
    logic [31:0] poll_cnt_q, poll_cnt_d;
    logic        res_err_q, res_err_d;
`endif

    // Upper read-data half is never part of a result.
    logic unused_bits;
`ifdef POLL_TIMEOUT_EN
    assign unused_bits = ^m_rdata[31:16];
`else
    assign unused_bits = ^{m_rdata[31:16], POLL_LAST[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCEPT;
            elem_cnt_q  <= '0;
            elem_reg_q  <= '0;
            last_flag_q <= 1'b0;
            wait_cnt_q  <= '0;
            step_cnt_q  <= '0;
            res_data_q  <= '0;
`ifdef POLL_TIMEOUT_EN
            poll_cnt_q  <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            elem_reg_q  <= elem_reg_d;
            last_flag_q <= last_flag_d;
            wait_cnt_q  <= wait_cnt_d;
            step_cnt_q  <= step_cnt_d;
            res_data_q  <= res_data_d;
`ifdef POLL_TIMEOUT_EN
            poll_cnt_q  <= poll_cnt_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        elem_reg_d  = elem_reg_q;
        last_flag_d = last_flag_q;
        wait_cnt_d  = wait_cnt_q;
        step_cnt_d  = step_cnt_q;
        res_data_d  = res_data_q;
`ifdef POLL_TIMEOUT_EN
        poll_cnt_d  = poll_cnt_q;
        res_err_d   = res_err_q;
`endif
        in_ready  = 1'b0;
        m_write   = 1'b0;
        m_read    = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        res_valid = 1'b0;

        case (state_q)
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    elem_reg_d  = in_data;
                    // Sticky: an early in_last still lets the current character finish.
                    last_flag_d = last_flag_q | in_last;
                    state_d     = WR_IN;
                end
            end
            WR_IN: begin
                m_write = 1'b1;
                m_addr  = 32'd1;
                m_wdata = {8'h00, elem_cnt_q, elem_reg_q};
                if (elem_cnt_q == ELEM_LAST) begin
                    elem_cnt_d = '0;
                    state_d    = START;
                end else begin
                    elem_cnt_d = elem_cnt_q + 8'd1;
                    state_d    = ACCEPT;
                end
            end
            START: begin
                m_write = 1'b1;
                if (step_cnt_q != 16'hFFFF) begin
                    step_cnt_d = step_cnt_q + 16'd1;
                end
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // The core is mid-step and must not be touched.
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = last_flag_q ? DENSE : ACCEPT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            DENSE: begin
                m_write = 1'b1;
                m_addr  = 32'd7;
`ifdef POLL_TIMEOUT_EN
                poll_cnt_d = '0;
`endif
                state_d = POLL;
            end
            POLL: begin
                m_read = 1'b1;
                if (m_rdata[0]) begin
                    state_d = READ;
                end else begin
`ifdef POLL_TIMEOUT_EN
                    if (poll_cnt_q == POLL_LAST) begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                        state_d    = OUT;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 32'd1;
                    end
`endif
                end
            end
            READ: begin
                // Reading the result also returns the core to its load state.
                m_read     = 1'b1;
                m_addr     = 32'd7;
                res_data_d = m_rdata[15:0];
`ifdef POLL_TIMEOUT_EN
                res_err_d  = 1'b0;
`endif
                state_d    = OUT;
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    step_cnt_d  = '0;
                    last_flag_d = 1'b0;
                    state_d     = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    assign res_data = res_data_q;
    assign step_cnt = step_cnt_q;
    assign busy     = !((state_q == ACCEPT) && (elem_cnt_q == 8'd0) && !last_flag_q);
`ifdef POLL_TIMEOUT_EN
    assign res_err  = res_err_q;
`else
    assign res_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// tb/tb_rnn_seq_ctrl.sv - Self-checking bench for rnn_seq_ctrl with a behavioural core model
module tb_rnn_seq_ctrl;

    localparam int EMB_LEN   = 4;
    localparam int STEP_WAIT = 16;
    localparam int POLL_MAX  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_data;
    logic        m_write, m_read;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        res_valid, res_ready, res_err, busy;
    logic [15:0] res_data, step_cnt;

    always #5 clk = ~clk;

    rnn_seq_ctrl #(.EMB_LEN(EMB_LEN), .STEP_WAIT(STEP_WAIT), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .m_write(m_write), .m_read(m_read), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .busy(busy), .step_cnt(step_cnt)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- core model ----------------
    logic        core_armed;
    int          polls_left;
    int          cfg_poll_delay;
    bit          cfg_never_ready;
    logic [15:0] core_result;

    always_comb begin
        m_rdata = '0;
        if (m_read) begin
            if (m_addr == 32'd0)
                m_rdata = {31'b0, core_armed && (polls_left == 0) && !cfg_never_ready};
            else if (m_addr == 32'd7)
                m_rdata = {16'hA5A5, core_result};
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            core_armed <= 1'b0;
            polls_left <= 0;
        end else if (m_write && m_addr == 32'd7) begin
            core_armed <= 1'b1;
            polls_left <= cfg_poll_delay;
        end else if (m_read && m_addr == 32'd0 && polls_left > 0) begin
            polls_left <= polls_left - 1;
        end else if (m_read && m_addr == 32'd7) begin
            core_armed <= 1'b0;
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } bus_t;

    bus_t trace[$];
    bus_t exp_q[$];
    bus_t mon_b;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_write || m_read) begin
            mon_b.rd   = m_read;
            mon_b.addr = m_addr;
            mon_b.data = m_read ? m_rdata : m_wdata;
            mon_b.cyc  = cyc;
            trace.push_back(mon_b);
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] seq_data[$];

    task automatic push_exp(input bit rd, input logic [31:0] addr, input logic [31:0] data);
        bus_t b;
        b.rd = rd; b.addr = addr; b.data = data; b.cyc = 0;
        exp_q.push_back(b);
    endtask

    // Bus traffic a whole sequence must produce: per character EMB_LEN indexed
    // element writes and a step start, then one dense trigger, the polls and the readout.
    task automatic build_exp(input int nch, input int pdel, input bit never, input logic [15:0] result);
        exp_q.delete();
        for (int c = 0; c < nch; c++) begin
            for (int e = 0; e < EMB_LEN; e++)
                push_exp(1'b0, 32'd1, {8'h00, e[7:0], seq_data[c * EMB_LEN + e]});
            push_exp(1'b0, 32'd0, 32'd0);
        end
        push_exp(1'b0, 32'd7, 32'd0);
        if (never) begin
            for (int p = 0; p < POLL_MAX; p++) push_exp(1'b1, 32'd0, 32'd0);
        end else begin
            for (int p = 0; p < pdel; p++) push_exp(1'b1, 32'd0, 32'd0);
            push_exp(1'b1, 32'd0, 32'd1);
            push_exp(1'b1, 32'd7, {16'hA5A5, result});
        end
    endtask

    task automatic compare_trace();
        int n;
        chk("trace_len", 64'(trace.size()), 64'(exp_q.size()));
        n = (trace.size() < exp_q.size()) ? trace.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("bus_%0d", i), {trace[i].rd, trace[i].addr[30:0], trace[i].data},
                {exp_q[i].rd, exp_q[i].addr[30:0], exp_q[i].data});
        for (int i = 0; i + 1 < trace.size(); i++)
            if (!trace[i].rd && trace[i].addr == 32'd0)
                chk("step_gap", 64'((trace[i + 1].cyc - trace[i].cyc) >= STEP_WAIT + 1), 64'd1);
        trace.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_elem(input logic [15:0] d, input logic l, input bit stall);
        int t = 0;
        if (stall) repeat ($urandom % 3) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && t < STEP_WAIT + 50) begin @(negedge clk); t++; end
        if (t >= STEP_WAIT + 50) chk("accept_wait", 64'(t), 64'(0));
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic finish_seq(input int nch, input bit never, input logic [15:0] result);
        int t = 0;
        int acc = 0;
        int budget = nch * (STEP_WAIT + 30) + 200;
        in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b1;
        while (!res_valid && t < budget) begin
            if (in_ready) acc++;
            @(negedge clk); t++;
        end
        chk("res_wait_in_budget", 64'(t < budget), 64'd1);
        in_valid = 1'b0; in_last = 1'b0;
        chk("no_accept_after_last", 64'(acc), 64'd0);
        chk("res_data", 64'(res_data), never ? 64'd0 : 64'(result));
        chk("res_err", 64'(res_err), 64'(never));
        chk("step_cnt_out", 64'(step_cnt), 64'(nch));
        chk("busy_out", 64'(busy), 64'd1);
        repeat ($urandom % 4) begin
            @(negedge clk);
            chk("res_held", 64'(res_valid), 64'd1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", 64'(res_valid), 64'd0);
        chk("step_cnt_clear", 64'(step_cnt), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        compare_trace();
    endtask

    task automatic run_seq(input int nch, input int last_idx, input int pdel, input bit never,
                           input logic [15:0] result, input bit stalls);
        cfg_poll_delay = pdel; cfg_never_ready = never; core_result = result;
        build_exp(nch, pdel, never, result);
        for (int i = 0; i < nch * EMB_LEN; i++)
            send_elem(seq_data[i], i == last_idx, stalls);
        finish_seq(nch, never, result);
    endtask

    typedef struct {
        logic [15:0] din;
        logic        dlast;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h0100, 1'b0, 32'h0000_0100};
        tbl[1] = '{16'h0080, 1'b0, 32'h0001_0080};
        tbl[2] = '{16'hFF00, 1'b0, 32'h0002_FF00};
        tbl[3] = '{16'h0000, 1'b1, 32'h0003_0000};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
        cfg_poll_delay = 0; cfg_never_ready = 1'b0; core_result = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_step_cnt", 64'(step_cnt), 64'd0);
        chk("rst_bus_idle", 64'({m_write, m_read}), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_res_err", 64'(res_err), 64'd0);
        trace.delete();

        // One character, table-driven element writes, 5 polls then result 0xFFE0.
        seq_data.delete();
        for (int i = 0; i < 4; i++) seq_data.push_back(tbl[i].din);
        cfg_poll_delay = 5; cfg_never_ready = 1'b0; core_result = 16'hFFE0;
        build_exp(1, 5, 1'b0, 16'hFFE0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = tbl[i].din; in_last = tbl[i].dlast;
            chk($sformatf("t1_ready_%0d", i), 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
            chk($sformatf("t1_wr_%0d", i), {m_write, m_read, m_addr, m_wdata[29:0]},
                {1'b1, 1'b0, 32'd1, tbl[i].exp_wdata[29:0]});
        end
        @(negedge clk);
        chk("t1_start", {m_write, m_addr, m_wdata}, {1'b1, 32'd0, 32'd0});
        begin
            int idle = 0;
            @(negedge clk);
            chk("t1_step_cnt", 64'(step_cnt), 64'd1);
            while (!(m_write || m_read) && idle < 1000) begin idle++; @(negedge clk); end
            chk("t1_wait_idle", 64'(idle), 64'(STEP_WAIT));
            chk("t1_dense", {m_write, m_addr}, {1'b1, 32'd7});
        end
        finish_seq(1, 1'b0, 16'hFFE0);

        // Three characters, last only on the final element.
        seq_data.delete();
        for (int i = 0; i < 12; i++) seq_data.push_back(16'(i * 16'h0111));
        run_seq(3, 11, 2, 1'b0, 16'h1234, 1'b0);

        // Early last on element 1 of character 2: character still completes.
        seq_data.delete();
        for (int i = 0; i < 8; i++) seq_data.push_back(16'($urandom));
        run_seq(2, 5, 0, 1'b0, 16'h8001, 1'b1);

        // Reset in the middle of a step wait.
        for (int i = 0; i < 4; i++) send_elem(16'h0F0F, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_step_cnt", 64'(step_cnt), 64'd0);
        chk("mid_rst_bus_idle", 64'({m_write, m_read}), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("post_rst_bus_idle", 64'({m_write, m_read}), 64'd0);
        trace.delete();

`ifdef POLL_TIMEOUT_EN
        // Core never signals completion: timeout result, no readout.
        seq_data.delete();
        for (int i = 0; i < 4; i++) seq_data.push_back(16'($urandom));
        run_seq(1, 3, 0, 1'b1, 16'h7777, 1'b0);
`endif

        // Randomised sequences against the model.
        for (int r = 0; r < 8; r++) begin
            int nch, li;
            nch = 1 + int'($urandom % 3);
            li  = (nch - 1) * EMB_LEN + int'($urandom % EMB_LEN);
            seq_data.delete();
            for (int i = 0; i < nch * EMB_LEN; i++) seq_data.push_back(16'($urandom));
            run_seq(nch, li, int'($urandom % 7), 1'b0, 16'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rnn_seq_ctrl.md
Name: rnn_seq_ctrl

Overview:
Bus-master sequencer for the RNN accelerator core. It accepts a stream of embedding elements, writes each character's vector into the core's input tensor and fires one recurrent step per character. After the last character it triggers the dense readout, polls for completion, reads the 16-bit fixed-point result and presents it on a valid/ready output. It sits between the host-side character stream and the core's read/write/addr/data port.

Parameters:
EMB_LEN, 4, elements per character vector (2^EMB_BITS of the core)
STEP_WAIT, 1100, cycles to wait after a step start before the next core access; must be ≥ the core's matmul + bias latency
POLL_MAX, 256, poll-attempt limit (used only with POLL_TIMEOUT_EN)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  element valid
in_ready  out  1  element accepted when in_valid & in_ready
in_data  in  16  signed fixed-point (8 fractional bits) embedding element
in_last  in  1  element belongs to the final character of the sequence
m_write  out  1  core write strobe
m_read  out  1  core read strobe
m_addr  out  32  core register address
m_wdata  out  32  core write data
m_rdata  in  32  core read data (combinational from m_read/m_addr)
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  16  signed dense-layer result
res_err  out  1  result invalid (timeout); 0 when feature disabled
busy  out  1  high in every state except ACCEPT with elem_cnt==0 and no latched last
step_cnt  out  16  characters stepped in current sequence

Behaviour:
- Reset (rst high at posedge): state=ACCEPT; elem_cnt, wait_cnt, poll_cnt, step_cnt=0; last_flag=0; all outputs 0 except in_ready=1. The core is not reset by this block; both must be reset together.
- All m_* outputs decode from registered state/holding regs; no combinational path in_* → m_*.
- States:
  - ACCEPT: in_ready=1. On handshake, capture in_data into elem_reg, OR in_last into last_flag, go to WR_IN.
  - WR_IN (1 cycle): m_write=1, m_addr=1, m_wdata={8'h00, elem_cnt[7:0], elem_reg}. If elem_cnt==EMB_LEN-1: elem_cnt←0, go to START. Else elem_cnt+1, go to ACCEPT.
  - START (1 cycle): m_write=1, m_addr=0, m_wdata=0; step_cnt+1 (saturates at 0xFFFF); wait_cnt←0; go to WAIT.
  - WAIT: all m_* idle. When wait_cnt==STEP_WAIT-1: go to DENSE if last_flag, else ACCEPT.
  - DENSE (1 cycle): m_write=1, m_addr=7, m_wdata=0; poll_cnt←0; go to POLL.
  - POLL: m_read=1, m_addr=0 every cycle. If m_rdata[0]==1 at the edge, go to READ. Else poll_cnt+1 and remain.
  - READ (1 cycle): m_read=1, m_addr=7. Capture res_data←m_rdata[15:0], res_err←0; go to OUT. This read returns the core to its load state.
  - OUT: res_valid=1, res_data held. On res_ready: step_cnt←0, last_flag←0, go to ACCEPT.
- Step latency: EMB_LEN×2 + 1 + STEP_WAIT cycles per character, given no input stalls.
- in_last on a non-final element of a character is latched and takes effect at the end of that character; partial characters are never started.
- in_valid is ignored outside ACCEPT. in_ready is 0 in all other states.
- res_valid is never deasserted without res_ready.
- rst mid-operation: immediate return to reset values; any pending result is discarded.

Optional Feature:
POLL_TIMEOUT_EN
- Defined: in POLL, if poll_cnt reaches POLL_MAX-1 without m_rdata[0], go to OUT with res_data=16'h0000 and res_err=1. No READ is issued.
- Undefined: POLL waits indefinitely; res_err is tied to 0 and poll_cnt is removed.

Test Plan:
- One char, elements 0x0100,0x0080,0xFF00,0x0000, last on element 3 → four writes addr 1 with m_wdata 0x00000100, 0x00010080, 0x0002FF00, 0x00030000; then addr-0 write; STEP_WAIT idle cycles; addr-7 write; polling.
- Model core returns m_rdata=0 for 5 polls, then 1 with result 0xFFE0 → exactly one READ at addr 7; res_data=0xFFE0, res_valid held until res_ready; step_cnt=1 during OUT, 0 after.
- Three-char sequence, in_last only on char 3 → three START writes each separated by ≥STEP_WAIT cycles; a single DENSE write; step_cnt=3.
- in_last on element 1 of char 2 → char 2 completes all four writes, then DENSE; no further elements accepted until the result handshake.
- rst pulsed during WAIT → next cycle state=ACCEPT, in_ready=1, step_cnt=0, no m_write/m_read.
- POLL_TIMEOUT_EN, POLL_MAX=8, core never ready → after 8 polls res_valid=1, res_err=1, res_data=0x0000, no addr-7 read.
